// File: rtl/hamming_pkg.sv
// Shared definitions for the extended-Hamming (SEC-DED) code family:
// parity-width sizing, codeword position mapping and error classes.
package hamming_pkg;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_SINGLE,
    ERR_PARITY,
    ERR_DOUBLE,
    ERR_UNCORR_RANGE
  } err_class_t;

  // Smallest r with 2^r >= k + r + 1; eight steps cover k up to 64.
  function automatic int unsigned calc_p_w(input int unsigned k);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << r) < k + r + 1) r = r + 1;
    end
    return r;
  endfunction

  function automatic logic is_pow2(input int unsigned i);
    return (i != 0) && ((i & (i - 1)) == 0);
  endfunction

  // Hamming position (1-based) holding data bit j.
  function automatic int unsigned data_pos(input int unsigned j);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned p = 1; p < 128; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == j && pos == 0) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_secded_syndrome.sv
// Combinational syndrome/overall-parity generator for an extended-Hamming
// codeword; shared between the decoder and the encoder checker.
module hamming_secded_syndrome
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned P_W    = calc_p_w(DATA_W),
  parameter int unsigned CODE_W = DATA_W + P_W + 1
) (
  input  logic [CODE_W-1:0] i_codeword,
  output logic [P_W-1:0]    o_syndrome,
  output logic              o_parity
);

  always_comb begin
    o_syndrome = '0;
    for (int unsigned i = 1; i < CODE_W; i++) begin
      if (i_codeword[i-1]) o_syndrome = o_syndrome ^ P_W'(i);
    end
    o_parity = ^i_codeword;
  end

endmodule

// File: rtl/hamming_secded_dec_pipe.sv
// Two-stage valid/ready SEC-DED decoder: stage 1 registers syndrome, overall
// parity and raw word; stage 2 classifies, corrects and feeds the counters.
module hamming_secded_dec_pipe
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned P_W    = calc_p_w(DATA_W),
  parameter int unsigned CODE_W = DATA_W + P_W + 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_codeword,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [P_W-1:0]    out_syndrome,
  output logic              out_corrected,
  output logic              out_uncorrectable,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  logic [P_W-1:0]    w_syn;
  logic              w_g;
  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_out_fire;
  logic              w_hit;
  logic [CODE_W-1:0] w_fix;
  logic [DATA_W-1:0] w_data;
  err_class_t        w_cls;

  logic              r_s1_valid;
  logic [P_W-1:0]    r_s1_syn;
  logic              r_s1_g;
  logic [CODE_W-1:0] r_s1_cw;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_data;
  logic [P_W-1:0]    r_syn;
  logic              r_corr;
  logic              r_uncorr;
  logic [CNT_W-1:0]  r_cnt_corr;
  logic [CNT_W-1:0]  r_cnt_uncorr;

  hamming_secded_syndrome #(
    .DATA_W (DATA_W),
    .P_W    (P_W),
    .CODE_W (CODE_W)
  ) u_syndrome (
    .i_codeword (in_codeword),
    .o_syndrome (w_syn),
    .o_parity   (w_g)
  );

  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign in_ready   = w_s1_adv && !rst;
  assign w_out_fire = r_s2_valid && out_ready;

  // A syndrome outside 1..CODE_W-1 matches no position, leaving w_hit low.
  always_comb begin
    w_hit = 1'b0;
    w_fix = r_s1_cw;
    for (int unsigned i = 1; i < CODE_W; i++) begin
      if (r_s1_g && r_s1_syn == P_W'(i)) begin
        w_hit      = 1'b1;
        w_fix[i-1] = ~w_fix[i-1];
      end
    end
    w_data = '0;
    for (int unsigned j = 0; j < DATA_W; j++) begin
      w_data[j] = w_fix[data_pos(j)-1];
    end
    w_cls = ERR_NONE;
    if (r_s1_g) begin
      if (r_s1_syn == '0) w_cls = ERR_PARITY;
      else if (w_hit)     w_cls = ERR_SINGLE;
      else                w_cls = ERR_UNCORR_RANGE;
    end else if (r_s1_syn != '0) begin
      w_cls = ERR_DOUBLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_syn   <= '0;
      r_s1_g     <= 1'b0;
      r_s1_cw    <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_syn <= w_syn;
        r_s1_g   <= w_g;
        r_s1_cw  <= in_codeword;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_data     <= '0;
      r_syn      <= '0;
      r_corr     <= 1'b0;
      r_uncorr   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data   <= w_data;
        r_syn    <= r_s1_syn;
        r_corr   <= (w_cls inside {ERR_SINGLE, ERR_PARITY});
        r_uncorr <= (w_cls inside {ERR_DOUBLE, ERR_UNCORR_RANGE});
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_corr   <= '0;
      r_cnt_uncorr <= '0;
    end else if (clr_cnt) begin
      r_cnt_corr   <= '0;
      r_cnt_uncorr <= '0;
    end else if (w_out_fire) begin
      if (r_corr && !(&r_cnt_corr))     r_cnt_corr   <= r_cnt_corr + 1'b1;
      if (r_uncorr && !(&r_cnt_uncorr)) r_cnt_uncorr <= r_cnt_uncorr + 1'b1;
    end
  end

  assign out_valid         = r_s2_valid;
  assign out_data          = r_data;
  assign out_syndrome      = r_syn;
  assign out_corrected     = r_corr;
  assign out_uncorrectable = r_uncorr;
  assign cnt_corr          = r_cnt_corr;
  assign cnt_uncorr        = r_cnt_uncorr;

endmodule

// File: tb/tb_hamming_secded_dec_pipe.sv
// Bench for hamming_secded_dec_pipe: a DATA_W=4/CNT_W=2 instance for streaming,
// backpressure and saturation, plus a DATA_W=8 instance for wider-code cases.
module tb_hamming_secded_dec_pipe;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  syn;
    logic        corr;
    logic        unc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid4, in_ready4, out_valid4, out_ready4, corr4, unc4, clr4;
  logic [7:0] cw4;
  logic [3:0] data4;
  logic [2:0] syn4;
  logic [1:0] cc4, cu4;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, corr8, unc8, clr8;
  logic [12:0] cw8;
  logic [7:0]  data8;
  logic [3:0]  syn8;
  logic [15:0] cc8, cu8;

  hamming_secded_dec_pipe #(.DATA_W(4), .CNT_W(2)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_codeword(cw4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(data4), .out_syndrome(syn4), .out_corrected(corr4),
    .out_uncorrectable(unc4), .clr_cnt(clr4), .cnt_corr(cc4), .cnt_uncorr(cu4)
  );

  hamming_secded_dec_pipe #(.DATA_W(8), .CNT_W(16)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_codeword(cw8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_data(data8), .out_syndrome(syn8), .out_corrected(corr8),
    .out_uncorrectable(unc8), .clr_cnt(clr8), .cnt_corr(cc8), .cnt_uncorr(cu8)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int mc = 0;
  int mu = 0;
  logic [7:0] in_q[$];
  exp_t       exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: works from the injected error positions, not the syndrome logic.
  function automatic int pw_of(input int k);
    int r = 1;
    while ((1 << r) < k + r + 1) r++;
    return r;
  endfunction

  function automatic bit is_par(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic int data_idx(input int p);
    int idx = 0;
    for (int q = 1; q < p; q++) if (!is_par(q)) idx++;
    return idx;
  endfunction

  function automatic logic [127:0] encode(input logic [63:0] d, input int k);
    int n;
    int j;
    bit par;
    logic [127:0] cw;
    n  = k + pw_of(k);
    j  = 0;
    cw = '0;
    for (int p = 1; p <= n; p++) begin
      if (!is_par(p)) begin
        cw[p-1] = d[j];
        j++;
      end
    end
    for (int b = 0; (1 << b) <= n; b++) begin
      par = 1'b0;
      for (int p = 1; p <= n; p++)
        if (((p >> b) & 1) != 0 && !is_par(p)) par ^= cw[p-1];
      cw[(1 << b) - 1] = par;
    end
    cw[n] = ^cw;
    return cw;
  endfunction

  // Error position 0 denotes the overall parity bit.
  function automatic logic [127:0] corrupt(input logic [127:0] cw, input int n,
                                           input int nerr, input int e0, input int e1, input int e2);
    int e[3];
    e = '{e0, e1, e2};
    for (int i = 0; i < nerr; i++) begin
      if (e[i] == 0) cw[n] = ~cw[n];
      else           cw[e[i]-1] = ~cw[e[i]-1];
    end
    return cw;
  endfunction

  function automatic exp_t model(input logic [63:0] d, input int k, input int nerr,
                                 input int e0, input int e1, input int e2);
    exp_t r;
    int e[3];
    int n;
    int s;
    bit g;
    logic [63:0] raw;
    e   = '{e0, e1, e2};
    n   = k + pw_of(k);
    s   = 0;
    raw = d;
    for (int i = 0; i < nerr; i++) begin
      s ^= e[i];
      if (e[i] != 0 && !is_par(e[i])) raw[data_idx(e[i])] = ~raw[data_idx(e[i])];
    end
    g      = (nerr % 2) == 1;
    r.syn  = 8'(s);
    r.corr = g && (s <= n);
    r.unc  = (!g && s != 0) || (g && s > n);
    r.data = r.corr ? d : raw;
    return r;
  endfunction

  task automatic push_lit(input logic [7:0] cw, input logic [3:0] d, input logic [2:0] s,
                          input logic c, input logic u);
    exp_t e;
    e.data = 64'(d);
    e.syn  = 8'(s);
    e.corr = c;
    e.unc  = u;
    in_q.push_back(cw);
    exp_q.push_back(e);
  endtask

  task automatic push_rand4(input int maxerr);
    logic [63:0]  d;
    logic [127:0] c;
    int nerr, e0, e1;
    d    = 64'($urandom_range(0, 15));
    nerr = $urandom_range(0, maxerr);
    e0   = $urandom_range(0, 7);
    do e1 = $urandom_range(0, 7); while (e1 == e0);
    c = corrupt(encode(d, 4), 7, nerr, e0, e1, 0);
    in_q.push_back(c[7:0]);
    exp_q.push_back(model(d, 4, nerr, e0, e1, 0));
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low for the first 3 cycles.
  task automatic run_stream(input int mode, input int max_cycles);
    logic [3:0] pd;
    logic [2:0] ps;
    logic       pc, pu, stalled;
    exp_t       e;
    int         cyc;
    stalled = 1'b0;
    cyc     = 0;
    pd = '0; ps = '0; pc = 1'b0; pu = 1'b0;
    while (exp_q.size() > 0 && cyc < max_cycles) begin
      in_valid4 = (in_q.size() > 0);
      cw4       = in_valid4 ? in_q[0] : 8'h00;
      case (mode)
        0:       out_ready4 = 1'b1;
        1:       out_ready4 = ($urandom_range(0, 3) != 0);
        default: out_ready4 = (cyc >= 3);
      endcase
      #1;
      if (stalled) begin
        check("stall_valid", 64'(out_valid4), 64'd1);
        check("stall_hold", 64'({data4, syn4, corr4, unc4}), 64'({pd, ps, pc, pu}));
      end
      check("flags_exclusive", 64'(corr4 & unc4), 64'd0);
      if (mode == 2 && cyc == 2) check("bp_in_ready", 64'(in_ready4), 64'd0);
      if (out_valid4 && out_ready4) begin
        check("no_extra_word", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", 64'(data4), e.data);
          check("out_syndrome", 64'(syn4), 64'(e.syn));
          check("out_corrected", 64'(corr4), 64'(e.corr));
          check("out_uncorrectable", 64'(unc4), 64'(e.unc));
          if (e.corr && mc < 3) mc++;
          if (e.unc && mu < 3) mu++;
        end
      end
      stalled = out_valid4 && !out_ready4;
      pd = data4; ps = syn4; pc = corr4; pu = unc4;
      if (in_valid4 && in_ready4) void'(in_q.pop_front());
      tick();
      cyc++;
      check("cnt_corr", 64'(cc4), 64'(mc));
      check("cnt_uncorr", 64'(cu4), 64'(mu));
    end
    in_valid4  = 1'b0;
    out_ready4 = 1'b0;
    check("stream_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send8(input logic [63:0] d, input int nerr, input int e0, input int e1,
                       input int e2, input string tag);
    logic [127:0] c;
    exp_t x;
    int t;
    c = corrupt(encode(d, 8), 12, nerr, e0, e1, e2);
    x = model(d, 8, nerr, e0, e1, e2);
    in_valid8  = 1'b1;
    cw8        = c[12:0];
    out_ready8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    t = 0;
    while (!out_valid8 && t < 4) begin
      tick();
      t++;
    end
    check({tag, "_valid"}, 64'(out_valid8), 64'd1);
    check({tag, "_data"}, 64'(data8), x.data);
    check({tag, "_syn"}, 64'(syn8), 64'(x.syn));
    check({tag, "_corr"}, 64'(corr8), 64'(x.corr));
    check({tag, "_unc"}, 64'(unc8), 64'(x.unc));
    tick();
  endtask

  initial begin
    rst = 1'b1;
    in_valid4 = 1'b0; out_ready4 = 1'b0; clr4 = 1'b0; cw4 = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; clr8 = 1'b0; cw8 = '0;
    #1;
    check("rst_in_ready", 64'(in_ready4), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid4), 64'd0);
    check("rst_out_bits", 64'({data4, syn4, corr4, unc4}), 64'd0);
    check("rst_counters", 64'({cc4, cu4}), 64'd0);
    check("post_rst_in_ready", 64'(in_ready4), 64'd1);

    // Latency: the capturing edge fills stage 1, the next edge presents the word.
    in_valid4  = 1'b1;
    cw4        = 8'h55;
    out_ready4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    check("lat_not_yet", 64'(out_valid4), 64'd0);
    tick();
    check("lat_valid", 64'(out_valid4), 64'd1);
    check("lat_data", 64'(data4), 64'b1011);
    check("lat_syn", 64'(syn4), 64'd0);
    check("lat_flags", 64'({corr4, unc4}), 64'd0);
    tick();
    check("lat_drained", 64'(out_valid4), 64'd0);
    out_ready4 = 1'b0;

    push_lit(8'h55, 4'b1011, 3'b000, 1'b0, 1'b0);
    push_lit(8'h45, 4'b1011, 3'b101, 1'b1, 1'b0);
    push_lit(8'hD5, 4'b1011, 3'b000, 1'b1, 1'b0);
    push_lit(8'h7D, 4'b1111, 3'b010, 1'b0, 1'b1);
    run_stream(0, 50);

    repeat (4) push_rand4(1);
    run_stream(2, 50);

    repeat (40) push_rand4(2);
    run_stream(1, 1000);

    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    mc = 0;
    mu = 0;
    check("clr_counters", 64'({cc4, cu4}), 64'd0);
    repeat (5) push_lit(8'h45, 4'b1011, 3'b101, 1'b1, 1'b0);
    run_stream(0, 50);
    check("cnt_saturated", 64'(cc4), 64'd3);

    // Clear coinciding with a counted handshake wins.
    in_valid4  = 1'b1;
    cw4        = 8'h45;
    out_ready4 = 1'b0;
    tick();
    in_valid4 = 1'b0;
    tick();
    check("clr_race_held", 64'(out_valid4), 64'd1);
    out_ready4 = 1'b1;
    clr4       = 1'b1;
    tick();
    clr4 = 1'b0;
    mc   = 0;
    check("clr_race_cnt", 64'(cc4), 64'd0);
    check("clr_race_gone", 64'(out_valid4), 64'd0);

    in_valid4 = 1'b1;
    cw4       = 8'h45;
    repeat (3) tick();
    check("pre_rst_cnt", 64'(cc4), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid4), 64'd0);
    check("midrst_counters", 64'({cc4, cu4}), 64'd0);
    check("midrst_in_ready", 64'(in_ready4), 64'd0);
    in_valid4 = 1'b0;
    tick();
    rst = 1'b0;
    mc  = 0;
    tick();
    tick();
    check("post_midrst_empty", 64'(out_valid4), 64'd0);

    send8(64'($urandom_range(0, 255)), 0, 0, 0, 0, "w8_clean");
    send8(64'($urandom_range(0, 255)), 3, 1, 4, 8, "w8_range");
    send8(64'($urandom_range(0, 255)), 1, 12, 0, 0, "w8_single");
    send8(64'($urandom_range(0, 255)), 2, 3, 12, 0, "w8_double");
    check("w8_cnt_corr", 64'(cc8), 64'd1);
    check("w8_cnt_uncorr", 64'(cu8), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
